// File: rtl/regfile_pkg.sv
// Shared sizing, index types and architectural register constants for the integer register file.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // x0 is hardwired to zero; x1..x3 are exposed on the debug/log outputs
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned LOG_IDX1 = 1;
  localparam int unsigned LOG_IDX2 = 2;
  localparam int unsigned LOG_IDX3 = 3;

  // True when a write at this edge actually lands in storage
  function automatic logic write_hits(input logic en, input logic rst, input reg_addr_t addr);
    return en && !rst && (addr != ADDR_WIDTH'(ZERO_REG));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: NUM_REGS:1 mux with x0 forced to zero.
// With REGFILE_WRITE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module regfile_read_port #(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]               addr,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic                                rst,
  input  logic                                write_en,
  input  logic [ADDR_WIDTH-1:0]               write_reg,
  input  logic [DATA_WIDTH-1:0]               write_data,
`endif
  output logic [DATA_WIDTH-1:0]               data
);

  import regfile_pkg::*;

  logic [DATA_WIDTH-1:0] mux_data;

  // x0 is never stored, so the mux default of zero covers it
  always_comb begin
    mux_data = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) mux_data = regs[i];
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // Write-first: the pending write wins over the stored value
  always_comb begin
    data = mux_data;
    if (write_en && !rst && (write_reg != ADDR_WIDTH'(ZERO_REG)) && (write_reg == addr))
      data = write_data;
  end
`else
  assign data = mux_data;
`endif

endmodule

// File: rtl/regfile.sv
// 32x32 RISC-V style integer register file: two async read ports, one sync write port, x1..x3 log taps.
// Build option: define REGFILE_WRITE_BYPASS_EN for write-first forwarding on the read ports.
module regfile #(
  parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] log_reg_1,
  output logic [DATA_WIDTH-1:0] log_reg_2,
  output logic [DATA_WIDTH-1:0] log_reg_3
);

  import regfile_pkg::*;

  // Storage for x1..x(NUM_REGS-1); x0 has no flops
  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs;

  // Reset beats write; writes to x0 are dropped by the decode
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (write_en) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (write_reg == ADDR_WIDTH'(i)) regs[i] <= write_data;
      end
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port1 (
    .regs       (regs),
    .addr       (read_reg1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst        (rst),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
`endif
    .data       (read_data1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port2 (
    .regs       (regs),
    .addr       (read_reg2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .rst        (rst),
    .write_en   (write_en),
    .write_reg  (write_reg),
    .write_data (write_data),
`endif
    .data       (read_data2)
  );

  // Debug taps come straight from storage and never see the bypass
  assign log_reg_1 = regs[LOG_IDX1];
  assign log_reg_2 = regs[LOG_IDX2];
  assign log_reg_3 = regs[LOG_IDX3];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed plan items plus randomized traffic against an array model.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] read_data1, read_data2, log_reg_1, log_reg_2, log_reg_3;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] model [32];

  regfile dut (
    .clk        (clk),
    .rst        (rst),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .write_en   (write_en),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .log_reg_1  (log_reg_1),
    .log_reg_2  (log_reg_2),
    .log_reg_3  (log_reg_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural read value as seen before the coming edge
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : model[a];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!rst && write_en && write_reg != 5'd0 && a == write_reg) v = write_data;
`endif
    return v;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (write_en && write_reg != 5'd0) begin
      model[write_reg] = write_data;
    end
  endfunction

  // Drive one cycle, check combinational outputs before the edge, then clock and update the model
  task automatic step(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input bit chk);
    rst = r; write_en = we; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2;
    #2;
    if (chk) begin
      check("rd1", read_data1, exp_read(r1));
      check("rd2", read_data2, exp_read(r2));
      check("log1", log_reg_1, model[1]);
      check("log2", log_reg_2, model[2]);
      check("log3", log_reg_3, model[3]);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_reads(input logic [4:0] r1, input logic [4:0] r2);
    rst = 1'b0; write_en = 1'b0; write_reg = 5'd0; write_data = 32'h0;
    read_reg1 = r1; read_reg2 = r2;
    #2;
  endtask

  initial begin
    rst = 1'b0; write_en = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk); #1;

    // Initial reset clears everything
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    idle_reads(5'd1, 5'd31);
    check("reset_rd1", read_data1, 32'h0);
    check("reset_rd2", read_data2, 32'h0);

    // Reset after writing x5
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1);
    idle_reads(5'd5, 5'd5);
    check("x5_written", read_data1, 32'hDEADBEEF);
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0);
    idle_reads(5'd5, 5'd0);
    check("x5_after_rst", read_data1, 32'h0);
    check("log1_after_rst", log_reg_1, 32'h0);
    check("log2_after_rst", log_reg_2, 32'h0);
    check("log3_after_rst", log_reg_3, 32'h0);

    // Sequential writes to x1..x3
    step(1'b0, 1'b1, 5'd1, 32'h00001511, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 5'd2, 32'h00000123, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 5'd3, 32'h00000312, 5'd0, 5'd0, 1'b1);
    idle_reads(5'd2, 5'd3);
    check("seq_log1", log_reg_1, 32'h00001511);
    check("seq_log2", log_reg_2, 32'h00000123);
    check("seq_log3", log_reg_3, 32'h00000312);
    check("seq_rd1_x2", read_data1, 32'h00000123);
    check("seq_rd2_x3", read_data2, 32'h00000312);

    // x0 hardwired, disabled write ignored
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
    idle_reads(5'd0, 5'd0);
    check("x0_rd1", read_data1, 32'h0);
    check("x0_rd2", read_data2, 32'h0);
    step(1'b0, 1'b0, 5'd1, 32'h0000AAAA, 5'd1, 5'd0, 1'b1);
    idle_reads(5'd1, 5'd0);
    check("we0_x1", read_data1, 32'h00001511);

    // Reset has priority over a simultaneous write
    step(1'b0, 1'b1, 5'd4, 32'h00005555, 5'd4, 5'd0, 1'b1);
    step(1'b1, 1'b1, 5'd4, 32'h00001234, 5'd4, 5'd0, 1'b0);
    idle_reads(5'd4, 5'd1);
    check("rst_wr_x4", read_data1, 32'h0);
    check("rst_wr_x1", read_data2, 32'h0);

    // Same-cycle read/write of x7
    step(1'b0, 1'b1, 5'd7, 32'h00000011, 5'd0, 5'd0, 1'b1);
    rst = 1'b0; write_en = 1'b1; write_reg = 5'd7; write_data = 32'h00000022;
    read_reg1 = 5'd7; read_reg2 = 5'd7;
    #2;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("x7_pre_edge", read_data1, 32'h00000022);
`else
    check("x7_pre_edge", read_data1, 32'h00000011);
`endif
    @(posedge clk);
    model_edge();
    #1;
    idle_reads(5'd7, 5'd0);
    check("x7_post_edge", read_data1, 32'h00000022);

    // Dual-port same address tracks log_reg_1
    step(1'b0, 1'b1, 5'd1, 32'hCAFEF00D, 5'd0, 5'd0, 1'b1);
    idle_reads(5'd1, 5'd1);
    check("dual_rd1", read_data1, 32'hCAFEF00D);
    check("dual_rd2", read_data2, 32'hCAFEF00D);
    check("dual_log1", log_reg_1, 32'hCAFEF00D);

    // Random traffic, biased toward low registers to exercise log taps and collisions
    for (int n = 0; n < 600; n++) begin
      logic        r, we;
      logic [4:0]  wr, r1, r2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 4));
      wd = $urandom;
      step(r, we, wr, wd, r1, r2, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
